// File: rtl/seq_signed_div.sv
// Sequential signed divider: restoring division on operand magnitudes, one
// quotient bit per cycle, followed by a sign fix-up cycle. Truncates toward zero.
module seq_signed_div #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_dvd;   // dividend magnitude, consumed MSB first
  logic [WIDTH-1:0] r_dsr;   // divisor magnitude
  logic [WIDTH-1:0] r_quo;   // quotient magnitude, filled LSB-ward
  logic [WIDTH:0]   r_rem;   // partial remainder
  logic [CW-1:0]    r_cnt;
  logic             r_sx;
  logic             r_sy;
  logic             r_dz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_done;
  logic             r_div_zero;

  logic             w_accept;
  logic [WIDTH:0]   w_xext;
  logic [WIDTH:0]   w_yext;
  logic [WIDTH:0]   w_ax;
  logic [WIDTH:0]   w_ay;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Operand magnitudes in WIDTH+1 bits so the most-negative value is safe.
  assign w_xext = {x[WIDTH-1], x};
  assign w_yext = {y[WIDTH-1], y};
  assign w_ax   = x[WIDTH-1] ? ({(WIDTH+1){1'b0}} - w_xext) : w_xext;
  assign w_ay   = y[WIDTH-1] ? ({(WIDTH+1){1'b0}} - w_yext) : w_yext;

  // Shift the next dividend bit in, then trial-subtract the divisor.
  assign w_shift = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dsr};

  // Sign fix-up; divide by zero forces an all-ones quotient.
  assign w_q_fix = r_dz ? {WIDTH{1'b1}} :
                   ((r_sx ^ r_sy) ? ({WIDTH{1'b0}} - r_quo) : r_quo);
  assign w_r_fix = r_sx ? ({WIDTH{1'b0}} - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state logic, handshake decode and busy flag.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b1;
    case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = StCalc;
        end
      end
      StCalc:  if (r_cnt == '0) w_state_next = StFix;
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, publish results in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dvd      <= '0;
      r_dsr      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_dz       <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_dvd      <= w_ax[WIDTH-1:0];
            r_dsr      <= w_ay[WIDTH-1:0];
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= CW'(WIDTH - 1);
            r_sx       <= x[WIDTH-1];
            r_sy       <= y[WIDTH-1];
            r_dz       <= (y == '0);
            r_div_zero <= 1'b0;
          end
        end
        StCalc: begin
          r_rem <= w_trial[WIDTH] ? w_shift : w_trial;
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
        end
        StFix: begin
          r_q        <= w_q_fix;
          r_r        <= w_r_fix;
          r_div_zero <= r_dz;
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign q        = r_q;
  assign r        = r_r;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule
